// File: rtl/switch_bounce_gen.sv
// rtl/switch_bounce_gen.sv - bouncing mechanical-switch waveform generator
// Turns a clean level command into N spaced toggles followed by a settle interval.
module switch_bounce_gen #(
  parameter int          CNT_W         = 16,
  parameter int          SETTLE_CYCLES = 1000,
  parameter int          GAP_MIN       = 8,
  parameter int          GAP_RAND_W    = 6,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_level,
  input  logic [3:0]       cfg_toggles,
  input  logic [CNT_W-1:0] cfg_gap,
  output logic             sw_out,
  output logic             busy,
  output logic             done
);

  // An all-zero LFSR would lock up, so a zero seed falls back to the default.
  localparam logic [15:0]      SEED        = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_BASE    = CNT_W'(GAP_MIN);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BOUNCE,
    ST_SETTLE
  } state_t;

  state_t           state_q, state_d;
  logic             sw_q, sw_d;
  logic             target_q, target_d;
  logic             done_q, done_d;
  logic [3:0]       tog_q, tog_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [15:0]      lfsr_q, lfsr_d;

  logic             lfsr_fb;
  logic [3:0]       n_sel;
  logic [CNT_W-1:0] g_sel;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_d  = {lfsr_q[14:0], lfsr_fb};

  // Random toggle counts are forced odd so the last toggle lands on the target.
  assign n_sel = (cfg_toggles != 4'd0) ? cfg_toggles : {lfsr_q[2:0], 1'b1};
  assign g_sel = (cfg_gap != '0) ? cfg_gap
               : GAP_BASE + CNT_W'(lfsr_q[GAP_RAND_W-1:0]);

  always_comb begin
    state_d  = state_q;
    sw_d     = sw_q;
    target_d = target_q;
    done_d   = 1'b0;
    tog_d    = tog_q;
    gap_d    = gap_q;
    settle_d = settle_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_level != sw_q) begin
          target_d = cmd_level;
          tog_d    = n_sel;
          gap_d    = g_sel;
          state_d  = ST_BOUNCE;
        end
      end
      ST_BOUNCE: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else begin
          sw_d  = ~sw_q;
          tog_d = tog_q - 4'd1;
          if (tog_q == 4'd1) begin
            state_d  = ST_SETTLE;
            settle_d = SETTLE_LOAD;
          end else begin
            gap_d = g_sel;
          end
        end
      end
      ST_SETTLE: begin
        // After an even toggle count this produces the one corrective edge.
        sw_d = target_q;
        if (settle_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sw_q     <= RESET_LEVEL;
      target_q <= RESET_LEVEL;
      done_q   <= 1'b0;
      tog_q    <= 4'd0;
      gap_q    <= '0;
      settle_q <= '0;
      lfsr_q   <= SEED;
    end else begin
      state_q  <= state_d;
      sw_q     <= sw_d;
      target_q <= target_d;
      done_q   <= done_d;
      tog_q    <= tog_d;
      gap_q    <= gap_d;
      settle_q <= settle_d;
      lfsr_q   <= lfsr_d;
    end
  end

  assign sw_out = sw_q;
  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// tb/tb_switch_bounce_gen.sv - self-checking bench for switch_bounce_gen
// Event-scheduled reference model plus directed and randomized bounce scenarios.
module tb_switch_bounce_gen;

  localparam int          CNT_W      = 16;
  localparam int          SETTLE     = 10;
  localparam int          GAP_MIN    = 8;
  localparam int          GAP_RAND_W = 6;
  localparam logic [15:0] SEED       = 16'hACE1;
  localparam logic        RST_LVL    = 1'b0;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_level = 1'b0;
  logic [3:0]       cfg_toggles = 4'd0;
  logic [CNT_W-1:0] cfg_gap = '0;
  logic             sw_out, busy, done;

  switch_bounce_gen #(
    .CNT_W(CNT_W), .SETTLE_CYCLES(SETTLE), .GAP_MIN(GAP_MIN),
    .GAP_RAND_W(GAP_RAND_W), .LFSR_SEED(SEED), .RESET_LEVEL(RST_LVL)
  ) dut (
    .clk(clk), .rst(rst), .cmd_level(cmd_level), .cfg_toggles(cfg_toggles),
    .cfg_gap(cfg_gap), .sw_out(sw_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: schedules absolute edge cycles from the bounce rules.
  bit          m_valid = 1'b0;
  int          m_mode = 0;     // 0 idle, 1 bouncing, 2 settling
  logic        m_sw, m_busy, m_done, m_target;
  int          m_next, m_rem, m_end;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int gap_of(input logic [CNT_W-1:0] g, input logic [15:0] l);
    return (g != 0) ? int'(g) : GAP_MIN + int'(l[GAP_RAND_W-1:0]);
  endfunction

  int   edges[$];
  int   busy_rise = -1;
  int   done_cyc = -1;
  int   n_done = 0;
  logic prev_sw = 1'b0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    if (m_valid) begin
      check("sw_out", sw_out, m_sw);
      check("busy", busy, m_busy);
      check("done", done, m_done);
    end
    if (sw_out !== prev_sw) edges.push_back(cyc);
    if (busy === 1'b1 && prev_busy !== 1'b1) busy_rise = cyc;
    if (done === 1'b1) begin
      done_cyc = cyc;
      n_done++;
    end
    prev_sw   = sw_out;
    prev_busy = busy;

    if (rst) begin
      m_valid = 1'b1;
      m_mode  = 0;
      m_sw    = RST_LVL;
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_lfsr  = SEED;
    end else if (m_valid) begin
      m_done = 1'b0;
      case (m_mode)
        0: if (cmd_level != m_sw) begin
             m_target = cmd_level;
             m_rem    = (cfg_toggles != 0) ? int'(cfg_toggles) : int'({m_lfsr[2:0], 1'b1});
             m_next   = cyc + 2 + gap_of(cfg_gap, m_lfsr);
             m_mode   = 1;
             m_busy   = 1'b1;
           end
        1: if (cyc + 1 == m_next) begin
             m_sw  = ~m_sw;
             m_rem = m_rem - 1;
             if (m_rem == 0) begin
               m_mode = 2;
               m_end  = cyc + 1 + SETTLE;
             end else begin
               m_next = cyc + 2 + gap_of(cfg_gap, m_lfsr);
             end
           end
        default: begin
          m_sw = m_target;
          if (cyc + 1 == m_end) begin
            m_mode = 0;
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end
      endcase
      m_lfsr = lstep(m_lfsr);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    i = 0;
    while (done !== 1'b1 && i < budget) begin
      step(1);
      i++;
    end
    check(tag, (i < budget), 1);
  endtask

  function automatic int edge_at(input int i);
    return (edges.size() > i) ? edges[i] : -1;
  endfunction

  int d[25];
  int rel0[$];
  int rel1[$];

  initial begin
    int k, s, cnt, r0, gap;
    bit ok;

    // Reset then idle
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    edges.delete();
    step(100);
    check("idle_edges", edges.size(), 0);
    check("idle_sw", sw_out, 0);
    check("idle_busy", busy, 0);
    check("idle_done_cnt", n_done, 0);

    // Deterministic odd bounce
    cfg_toggles = 4'd3;
    cfg_gap     = 16'd3;
    cmd_level   = 1'b1;
    k = cyc;
    edges.delete();
    wait_done("odd_timeout", 200);
    step(2);
    check("odd_busy_rise", busy_rise, k + 1);
    check("odd_n_edges", edges.size(), 3);
    check("odd_edge0", edge_at(0), k + 5);
    check("odd_edge1", edge_at(1), k + 9);
    check("odd_edge2", edge_at(2), k + 13);
    check("odd_done_cyc", done_cyc, k + 23);
    check("odd_busy_after", busy, 0);
    check("odd_final", sw_out, 1);

    // Deterministic even bounce, 1 -> 0
    cfg_toggles = 4'd2;
    cfg_gap     = 16'd1;
    cmd_level   = 1'b0;
    k = cyc;
    edges.delete();
    wait_done("even_timeout", 200);
    step(2);
    check("even_n_edges", edges.size(), 3);
    check("even_edge0", edge_at(0), k + 3);
    check("even_edge1", edge_at(1), k + 5);
    check("even_edge2", edge_at(2), k + 6);
    check("even_done_cyc", done_cyc, k + 15);
    check("even_final", sw_out, 0);

    // Command change during bounce is deferred
    cfg_toggles = 4'd5;
    cfg_gap     = 16'd4;
    cmd_level   = 1'b1;
    step(10);
    cmd_level = 1'b0;
    wait_done("mid_timeout1", 400);
    check("mid_level_at_done", sw_out, 1);
    step(1);
    check("mid_restart_busy", busy, 1);
    wait_done("mid_timeout2", 400);
    check("mid_final", sw_out, 0);

    // Random mode, two passes from reset for repeatability
    cfg_toggles = 4'd0;
    cfg_gap     = '0;
    foreach (d[i]) d[i] = $urandom_range(0, 5);
    for (int p = 0; p < 2; p++) begin
      cmd_level = 1'b0;
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      r0 = cyc;
      edges.delete();
      for (int i = 0; i < 25; i++) begin
        step(d[i]);
        s = edges.size();
        cmd_level = ~cmd_level;
        wait_done("rand_timeout", 3000);
        step(2);
        cnt = edges.size() - s;
        check("rand_n_odd", cnt % 2, 1);
        check("rand_n_le15", (cnt <= 15), 1);
        ok = 1'b1;
        for (int j = s + 1; j < edges.size(); j++) begin
          gap = edges[j] - edges[j-1];
          if (gap < GAP_MIN + 1 || gap > GAP_MIN + 64) ok = 1'b0;
        end
        check("rand_gap_range", ok, 1);
        check("rand_final", sw_out, cmd_level);
      end
      foreach (edges[j]) begin
        if (p == 0) rel0.push_back(edges[j] - r0);
        else        rel1.push_back(edges[j] - r0);
      end
    end
    check("repeat_len", rel1.size(), rel0.size());
    foreach (rel0[j]) check("repeat_edge", (j < rel1.size()) ? rel1[j] : -1, rel0[j]);

    // Reset mid-bounce
    cfg_toggles = 4'd4;
    cfg_gap     = 16'd6;
    cmd_level   = ~sw_out;
    step(5);
    check("rmb_busy_before", busy, 1);
    s = n_done;
    rst = 1'b1;
    step(1);
    check("rmb_sw", sw_out, RST_LVL);
    check("rmb_busy", busy, 0);
    check("rmb_done", done, 0);
    rst = 1'b0;
    cmd_level = 1'b0;
    step(3);
    check("rmb_no_done", n_done, s);
    cmd_level = 1'b1;
    wait_done("rmb_timeout", 400);
    step(1);
    check("rmb_resume", sw_out, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/switch_bounce_gen.md
Name: switch_bounce_gen

Overview:
- Generates a realistic bouncing mechanical-switch waveform from a clean level command. It is the stimulus side of the switch debouncer.
- Used on the Spartan-6 board and in simulation to drive the debouncer input path with repeatable or pseudorandom bounce, without physical switch presses.
- Each commanded level change produces N toggles with programmable spacing, then a guaranteed settle interval at the new level.

Parameters:
- CNT_W, 16, width of the gap and settle counters.
- SETTLE_CYCLES, 1000, cycles `sw_out` is held stable at target after bouncing (≥1).
- GAP_MIN, 8, minimum random gap value when `cfg_gap==0`.
- GAP_RAND_W, 6, number of LFSR bits added to GAP_MIN for random gaps.
- LFSR_SEED, 16'hACE1, LFSR reset value; a seed of 0 is replaced by 16'hACE1.
- RESET_LEVEL, 1'b0, `sw_out` level after reset.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- cmd_level  input  1  clean desired switch level; synchronous to `clk`.
- cfg_toggles  input  4  bounce toggle count N; 0 selects random N.
- cfg_gap  input  CNT_W  gap value G between toggles; 0 selects random G.
- sw_out  output  1  bouncing switch output; registered.
- busy  output  1  high while in BOUNCE or SETTLE.
- done  output  1  one-cycle pulse when SETTLE completes.

Behaviour:
- Reset: takes effect at the clock edge while `rst=1`, and aborts any operation in progress.
  - State=IDLE, `sw_out`=RESET_LEVEL, `busy`=0, `done`=0, LFSR=seed, counters=0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle when not in reset and never reaches 0.
- States: IDLE, BOUNCE, SETTLE.
- IDLE:
  - `sw_out` holds its value and `busy`=0.
  - If `cmd_level != sw_out` in cycle k, then at edge k+1:
    - latch target = `cmd_level`;
    - load toggles_left = N, where N = `cfg_toggles` if nonzero, else {LFSR[2:0],1'b1} (odd, 1..15);
    - load gap_cnt = G, where G = `cfg_gap` if nonzero, else GAP_MIN + LFSR[GAP_RAND_W-1:0];
    - state → BOUNCE, `busy`=1.
- BOUNCE:
  - If gap_cnt ≠ 0: decrement gap_cnt.
  - If gap_cnt == 0:
    - `sw_out` toggles at the next edge and toggles_left decrements;
    - gap_cnt reloads with a fresh G, re-evaluated from `cfg_gap`/LFSR at each reload;
    - if toggles_left was 1, state → SETTLE instead, with settle_cnt = SETTLE_CYCLES-1.
  - Consecutive toggles are therefore G+1 cycles apart. The first toggle occurs G+1 cycles after BOUNCE entry.
- SETTLE:
  - `sw_out` is driven to target on SETTLE entry. When N is even this is one extra edge; when N is odd `sw_out` already equals target and no edge occurs.
  - settle_cnt counts down. When it reaches 0: state → IDLE, `busy`=0, and `done`=1 for exactly that one cycle.
  - Total SETTLE duration is SETTLE_CYCLES cycles.
- Command changes during BOUNCE/SETTLE are ignored; target is not updated.
  - On return to IDLE, a `cmd_level` different from `sw_out` starts a new bounce on the next edge. `done` and the new `busy` may therefore be adjacent cycles.
- `cfg_toggles`/`cfg_gap` are sampled only at load points; changes mid-bounce affect only later reloads (gap) or later bounces (toggles).
- `cmd_level == sw_out` in IDLE: no activity, no `done`.
- `sw_out` never glitches combinationally; it is driven from a register.

Test Plan:
- Reset then idle: `rst`=1 for 2 cycles with RESET_LEVEL=0, `cmd_level`=0 → `sw_out`=0, `busy`=0, `done`=0 for 100 cycles; no edges.
- Deterministic odd bounce: `cfg_toggles`=3, `cfg_gap`=3, SETTLE_CYCLES=10; `cmd_level` 0→1 seen at cycle k →
  - `busy` rises at k+1;
  - `sw_out` edges at k+5 (1), k+9 (0), k+13 (1);
  - SETTLE with no extra edge;
  - `done` pulse at k+23, `busy` low after it.
- Deterministic even bounce: `cfg_toggles`=2, `cfg_gap`=1, `cmd_level` 1→0 → toggles 1→0→1 two cycles apart, then a forced edge to 0 on SETTLE entry; 3 edges total; final `sw_out`=0.
- Mid-operation command change: start a bounce to 1, drop `cmd_level` to 0 during BOUNCE → bounce finishes at 1, `done` pulses, a new bounce to 0 starts the next cycle, and the final level is 0.
- Random mode: `cfg_toggles`=0, `cfg_gap`=0, 50 random commands →
  - edge count per bounce is odd and ≤15;
  - every inter-toggle gap lies in [GAP_MIN+1, GAP_MIN+64];
  - the sequence repeats identically after reset with the same seed.
- Reset mid-bounce: assert `rst` during BOUNCE → next cycle `sw_out`=RESET_LEVEL, `busy`=0, no `done`; normal operation resumes after `rst` is released.
